// File: rtl/color_lane_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : color_lane_fifo_if
// Brief    : Per-lane producer (blue) and consumer (black) valid/ready bus.
// Revision : 1.0 - initial release
// ============================================================================
interface color_lane_fifo_if #(
   parameter int N_LANE = 2,
   parameter int WIDTH  = 1
);
   logic [N_LANE*WIDTH-1:0] i_blue;
   logic [N_LANE-1:0]       i_blue_valid;
   logic [N_LANE-1:0]       o_blue_ready;
   logic [N_LANE*WIDTH-1:0] o_black;
   logic [N_LANE-1:0]       o_black_valid;
   logic [N_LANE-1:0]       i_black_ready;

   // Names are from the FIFO's point of view; the master drives the i_* side.
   modport master (
      output i_blue, i_blue_valid, i_black_ready,
      input  o_blue_ready, o_black, o_black_valid
   );

   modport slave (
      input  i_blue, i_blue_valid, i_black_ready,
      output o_blue_ready, o_black, o_black_valid
   );
endinterface
`default_nettype wire

// File: rtl/color_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : color_lane_fifo
// Brief    : N_LANE independent show-ahead FIFOs with optional lockstep pop.
// Revision : 1.0 - initial release
// ============================================================================
module color_lane_fifo #(
   parameter int N_LANE   = 2,
   parameter int WIDTH    = 1,
   parameter int DEPTH    = 4,
   parameter int LOCKSTEP = 0
) (
   input  wire logic         i_clk,
   input  wire logic         i_rst_n,
   input  wire logic         i_red,
   color_lane_fifo_if.slave  bus,
   output logic              o_green,
   output logic              o_pink
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
   localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);

   logic [WIDTH-1:0] r_mem    [N_LANE][DEPTH];
   logic [c_AW-1:0]  r_wr_ptr [N_LANE];
   logic [c_AW-1:0]  r_rd_ptr [N_LANE];
   logic [c_CW-1:0]  r_count  [N_LANE];

   logic              w_live;
   logic [N_LANE-1:0] w_not_empty;
   logic [N_LANE-1:0] w_full;
   logic [N_LANE-1:0] w_ready;
   logic [N_LANE-1:0] w_valid;
   logic [N_LANE-1:0] w_push;
   logic [N_LANE-1:0] w_pop;

   // Handshakes are masked both by reset and by the global enable.
   assign w_live = i_rst_n & i_red;

   always_comb begin
      w_not_empty = '0;
      w_full      = '0;
      bus.o_black = '0;
      for (int n = 0; n < N_LANE; n++) begin
         w_not_empty[n] = (r_count[n] != '0);
         w_full[n]      = (r_count[n] == c_FULL);
         if (i_rst_n) begin
            bus.o_black[n*WIDTH +: WIDTH] = r_mem[n][r_rd_ptr[n]];
         end
      end
   end

   assign w_ready = {N_LANE{w_live}} & ~w_full;
   assign w_push  = bus.i_blue_valid & w_ready;

   generate
      if (LOCKSTEP != 0) begin : g_lockstep
         // All lanes present data together and pop all-or-none.
         assign w_valid = {N_LANE{w_live & (&w_not_empty)}};
         assign w_pop   = {N_LANE{(&w_valid) & (&bus.i_black_ready)}};
      end else begin : g_independent
         assign w_valid = {N_LANE{w_live}} & w_not_empty;
         assign w_pop   = w_valid & bus.i_black_ready;
      end
   endgenerate

   assign bus.o_blue_ready  = w_ready;
   assign bus.o_black_valid = w_valid;
   assign o_green = ~i_rst_n | ~(|w_not_empty);
   assign o_pink  = i_rst_n & (|w_full);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int n = 0; n < N_LANE; n++) begin
            r_wr_ptr[n] <= '0;
            r_rd_ptr[n] <= '0;
            r_count[n]  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_mem[n][i] <= '0;
            end
         end
      end else begin
         for (int n = 0; n < N_LANE; n++) begin
            if (w_push[n]) begin
               r_mem[n][r_wr_ptr[n]] <= bus.i_blue[n*WIDTH +: WIDTH];
               r_wr_ptr[n]           <= r_wr_ptr[n] + c_PTR_ONE;
            end
            if (w_pop[n]) begin
               r_rd_ptr[n] <= r_rd_ptr[n] + c_PTR_ONE;
            end
            if (w_push[n] && !w_pop[n]) begin
               r_count[n] <= r_count[n] + c_CNT_ONE;
            end else if (!w_push[n] && w_pop[n]) begin
               r_count[n] <= r_count[n] - c_CNT_ONE;
            end
         end
      end
   end
endmodule
`default_nettype wire
